// File: rtl/calc_pkg.sv
// Calculator sequencer shared definitions.
//   state_t  : control FSM states
//   DISP_*   : disp_sel source codes
//   OPC_*    : operator key codes
//   *_DEF    : default operand digit count and ALU timeout
package calc_pkg;

   localparam int unsigned NDIG_DEF    = 4;
   localparam int unsigned TIMEOUT_DEF = 31;

   typedef enum logic [1:0] {
      S_OP1  = 2'd0,
      S_OP2  = 2'd1,
      S_EXEC = 2'd2,
      S_RES  = 2'd3
   } state_t;

   localparam logic [1:0] DISP_OP1 = 2'b00;
   localparam logic [1:0] DISP_OPR = 2'b01;
   localparam logic [1:0] DISP_OP2 = 2'b10;
   localparam logic [1:0] DISP_RES = 2'b11;

   localparam logic [1:0] OPC_A = 2'b01;
   localparam logic [1:0] OPC_B = 2'b10;

endpackage

// File: rtl/calc_sequencer_bcd_entry_reg.sv
// BCD operand entry register: shift register plus digit counter.
//   clk, reset  : clock, synchronous active-high reset
//   i_clr       : clear value and count (priority over load/shift)
//   i_load      : load i_load_val / i_load_cnt
//   i_shift     : shift i_digit in at the LSD and bump the count
//   o_val/o_cnt : current operand and number of digits entered
// Digit validity and the full-count guard are owned by the caller.
module bcd_entry_reg #(
   parameter int unsigned NDIG = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        i_clr,
   input  logic                        i_load,
   input  logic [4*NDIG-1:0]           i_load_val,
   input  logic [$clog2(NDIG+1)-1:0]   i_load_cnt,
   input  logic                        i_shift,
   input  logic [3:0]                  i_digit,
   output logic [4*NDIG-1:0]           o_val,
   output logic [$clog2(NDIG+1)-1:0]   o_cnt
);

   localparam int unsigned CW = $clog2(NDIG+1);

   logic [4*NDIG-1:0] r_val;
   logic [CW-1:0]     r_cnt;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_val <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_val <= i_load_val;
         r_cnt <= i_load_cnt;
      end else if (i_shift) begin
         r_val <= {r_val[4*NDIG-5:0], i_digit};
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_val = r_val;
   assign o_cnt = r_cnt;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: collects two BCD operands and an operator,
// launches the ALU, waits (bounded) for its result and drives the display
// source select.
//   clk, reset            : clock, synchronous active-high reset
//   num/digit             : digit key strobe and BCD digit
//   op/operator           : operator key strobe and code
//   c, equ                : clear and equals strobes
//   alu_done/res/neg      : ALU result handshake
//   op1, op2, op_sel      : operands and operator to the ALU
//   alu_start             : one-cycle ALU launch pulse
//   result, neg           : latched ALU result and sign
//   disp_sel, busy, err   : display source, executing flag, sticky timeout
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned NDIG    = NDIG_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                num,
   input  logic [3:0]          digit,
   input  logic                op,
   input  logic [1:0]          operator,
   input  logic                c,
   input  logic                equ,
   input  logic                alu_done,
   input  logic [4*NDIG-1:0]   alu_res,
   input  logic                alu_neg,
   output logic [4*NDIG-1:0]   op1,
   output logic [4*NDIG-1:0]   op2,
   output logic [1:0]          op_sel,
   output logic                alu_start,
   output logic [4*NDIG-1:0]   result,
   output logic                neg,
   output logic [1:0]          disp_sel,
   output logic                busy,
   output logic                err
);

   localparam int unsigned WOP = 4*NDIG;
   localparam int unsigned CW  = $clog2(NDIG+1);
   localparam int unsigned TW  = $clog2(TIMEOUT+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(NDIG);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_op_sel, r_disp, w_disp_nxt;
   logic [WOP-1:0]   r_result;
   logic             r_neg, r_err, r_alu_start;
   logic [TW-1:0]    r_tmo;

   logic [CW-1:0]    w_cnt1, w_cnt2;
   logic             w_dig_ok, w_clr_all, w_clr2, w_ld1, w_sh1, w_sh2;
   logic             w_opsel_ld, w_start, w_cap, w_tmo_fire, w_op2_nz_nxt;
   logic [WOP-1:0]   w_ld1_val;
   logic [CW-1:0]    w_ld1_cnt;

   bcd_entry_reg #(.NDIG(NDIG)) u_op1 (
      .clk(clk), .reset(reset), .i_clr(w_clr_all), .i_load(w_ld1),
      .i_load_val(w_ld1_val), .i_load_cnt(w_ld1_cnt), .i_shift(w_sh1),
      .i_digit(digit), .o_val(op1), .o_cnt(w_cnt1)
   );

   bcd_entry_reg #(.NDIG(NDIG)) u_op2 (
      .clk(clk), .reset(reset), .i_clr(w_clr_all | w_clr2), .i_load(1'b0),
      .i_load_val('0), .i_load_cnt('0), .i_shift(w_sh2),
      .i_digit(digit), .o_val(op2), .o_cnt(w_cnt2)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_OP1;
      else       r_state <= w_state_nxt;
   end

   // Strict key priority c > equ > op > num: a higher strobe that is
   // ignored in the current state still swallows the lower ones.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_all   = 1'b0;
      w_clr2      = 1'b0;
      w_ld1       = 1'b0;
      w_ld1_val   = '0;
      w_ld1_cnt   = '0;
      w_sh1       = 1'b0;
      w_sh2       = 1'b0;
      w_opsel_ld  = 1'b0;
      w_start     = 1'b0;
      w_cap       = 1'b0;
      w_tmo_fire  = 1'b0;
      w_dig_ok    = num && (digit <= 4'd9);
      if (c) begin
         w_clr_all   = 1'b1;
         w_state_nxt = S_OP1;
      end else begin
         case (r_state)
            S_OP1: begin
               if (equ) begin
               end else if (op) begin
                  w_opsel_ld  = 1'b1;
                  w_clr2      = 1'b1;
                  w_state_nxt = S_OP2;
               end else if (w_dig_ok) begin
                  w_sh1 = (w_cnt1 != CNT_MAX);
               end
            end
            S_OP2: begin
               if (equ) begin
                  if (w_cnt2 != '0) begin
                     w_start     = 1'b1;
                     w_state_nxt = S_EXEC;
                  end
               end else if (op) begin
                  w_opsel_ld = (w_cnt2 == '0);
               end else if (w_dig_ok) begin
                  w_sh2 = (w_cnt2 != CNT_MAX);
               end
            end
            S_EXEC: begin
               if (alu_done) begin
                  w_cap       = 1'b1;
                  w_state_nxt = S_RES;
               end else if (r_tmo == TMO_MAX) begin
                  w_tmo_fire  = 1'b1;
                  w_state_nxt = S_RES;
               end
            end
            S_RES: begin
               if (equ) begin
               end else if (op) begin
                  // chain: previous result becomes the first operand
                  w_opsel_ld  = 1'b1;
                  w_ld1       = 1'b1;
                  w_ld1_val   = r_result;
                  w_ld1_cnt   = CNT_MAX;
                  w_clr2      = 1'b1;
                  w_state_nxt = S_OP2;
               end else if (w_dig_ok) begin
                  w_ld1       = 1'b1;
                  w_ld1_val   = WOP'(digit);
                  w_ld1_cnt   = CW'(1);
                  w_clr2      = 1'b1;
                  w_state_nxt = S_OP1;
               end
            end
            default: w_state_nxt = S_OP1;
         endcase
      end
      // disp_sel is decoded from the next state so the register tracks
      // the state it is registered alongside.
      w_op2_nz_nxt = ((w_cnt2 != '0) && !w_clr2) || w_sh2;
      case (w_state_nxt)
         S_OP1:   w_disp_nxt = DISP_OP1;
         S_OP2:   w_disp_nxt = w_op2_nz_nxt ? DISP_OP2 : DISP_OPR;
         S_EXEC:  w_disp_nxt = DISP_OP2;
         default: w_disp_nxt = DISP_RES;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_sel    <= '0;
         r_result    <= '0;
         r_neg       <= 1'b0;
         r_err       <= 1'b0;
         r_alu_start <= 1'b0;
         r_disp      <= DISP_OP1;
         r_tmo       <= '0;
      end else begin
         r_alu_start <= w_start;
         r_disp      <= w_disp_nxt;
         r_tmo       <= (r_state == S_EXEC && w_state_nxt == S_EXEC) ? r_tmo + TW'(1) : '0;
         if (w_clr_all) begin
            r_op_sel <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
         end else begin
            if (w_opsel_ld) r_op_sel <= operator;
            if (w_cap) begin
               r_result <= alu_res;
               r_neg    <= alu_neg;
            end else if (w_tmo_fire) begin
               r_result <= '0;
               r_neg    <= 1'b0;
               r_err    <= 1'b1;
            end
         end
      end
   end

   assign op_sel    = r_op_sel;
   assign alu_start = r_alu_start;
   assign result    = r_result;
   assign neg       = r_neg;
   assign disp_sel  = r_disp;
   assign busy      = (r_state == S_EXEC);
   assign err       = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: a cycle-by-cycle key table with
// hand-computed expected outputs, plus hand-written timeout and
// reset-during-execute sequences.
module tb_calc_sequencer;

   localparam int unsigned TMO = 31;

   logic        clk = 1'b0;
   logic        reset, num, op, c, equ, alu_done, alu_neg;
   logic [3:0]  digit;
   logic [1:0]  operator;
   logic [15:0] alu_res;
   logic [15:0] op1, op2, result;
   logic [1:0]  op_sel, disp_sel;
   logic        alu_start, neg, busy, err;

   int n_checks = 0;
   int n_errors = 0;

   calc_sequencer #(.NDIG(4), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .num(num), .digit(digit), .op(op),
      .operator(operator), .c(c), .equ(equ), .alu_done(alu_done),
      .alu_res(alu_res), .alu_neg(alu_neg), .op1(op1), .op2(op2),
      .op_sel(op_sel), .alu_start(alu_start), .result(result), .neg(neg),
      .disp_sel(disp_sel), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        c, equ, op;
      logic [1:0]  opr;
      logic        num;
      logic [3:0]  dig;
      logic        done;
      logic [15:0] res;
      logic        rneg;
      logic [15:0] e_op1, e_op2;
      logic [1:0]  e_sel;
      logic        e_start;
      logic [15:0] e_result;
      logic        e_neg;
      logic [1:0]  e_disp;
      logic        e_busy, e_err;
   } vec_t;

   vec_t vq[$];

   task automatic add(input string n, input logic vc, vequ, vop, input logic [1:0] vopr,
                      input logic vnum, input logic [3:0] vdig, input logic vdone,
                      input logic [15:0] vres, input logic vneg,
                      input logic [15:0] eop1, eop2, input logic [1:0] esel, input logic est,
                      input logic [15:0] eres, input logic eneg, input logic [1:0] edisp,
                      input logic ebusy, eerr);
      vec_t v;
      v.name = n; v.c = vc; v.equ = vequ; v.op = vop; v.opr = vopr; v.num = vnum;
      v.dig = vdig; v.done = vdone; v.res = vres; v.rneg = vneg;
      v.e_op1 = eop1; v.e_op2 = eop2; v.e_sel = esel; v.e_start = est;
      v.e_result = eres; v.e_neg = eneg; v.e_disp = edisp; v.e_busy = ebusy; v.e_err = eerr;
      vq.push_back(v);
   endtask

   // Drive one cycle of inputs at the falling edge; return 1ns after the
   // rising edge that samples them.
   task automatic step(input logic vc, vequ, vop, input logic [1:0] vopr, input logic vnum,
                       input logic [3:0] vdig, input logic vdone, input logic [15:0] vres,
                       input logic vneg);
      @(negedge clk);
      c = vc; equ = vequ; op = vop; operator = vopr; num = vnum; digit = vdig;
      alu_done = vdone; alu_res = vres; alu_neg = vneg;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 2'b00, 0, 4'h0, 0, 16'h0, 0);
   endtask

   task automatic expect_all(input string n, input logic [15:0] eop1, eop2,
                             input logic [1:0] esel, input logic est, input logic [15:0] eres,
                             input logic eneg, input logic [1:0] edisp, input logic ebusy, eerr);
      n_checks++;
      if ({op1, op2, op_sel, alu_start, result, neg, disp_sel, busy, err} !==
          {eop1, eop2, esel, est, eres, eneg, edisp, ebusy, eerr}) begin
         n_errors++;
         $display("FAIL %s: got op1=%h op2=%h sel=%b start=%b res=%h neg=%b disp=%b busy=%b err=%b; want op1=%h op2=%h sel=%b start=%b res=%h neg=%b disp=%b busy=%b err=%b",
                  n, op1, op2, op_sel, alu_start, result, neg, disp_sel, busy, err,
                  eop1, eop2, esel, est, eres, eneg, edisp, ebusy, eerr);
      end
   endtask

   initial begin
      reset = 1'b1; num = 0; op = 0; c = 0; equ = 0; alu_done = 0; alu_neg = 0;
      digit = '0; operator = '0; alu_res = '0;

      //   name          c e o opr n dig d  res       rn  op1      op2      sel st result   ng disp bz er
      // keys 1 2 A 3 =, ALU answers three cycles after equ
      add("A_num1",     0,0,0,2'd0,1,4'h1,0,16'h0000,0, 16'h0001,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("A_num2",     0,0,0,2'd0,1,4'h2,0,16'h0000,0, 16'h0012,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("A_opA",      0,0,1,2'd1,0,4'h0,0,16'h0000,0, 16'h0012,16'h0000,2'd1,0,16'h0000,0,2'd1,0,0);
      add("A_num3",     0,0,0,2'd0,1,4'h3,0,16'h0000,0, 16'h0012,16'h0003,2'd1,0,16'h0000,0,2'd2,0,0);
      add("A_equ",      0,1,0,2'd0,0,4'h0,0,16'h0000,0, 16'h0012,16'h0003,2'd1,1,16'h0000,0,2'd2,1,0);
      add("A_wait1",    0,0,0,2'd0,0,4'h0,0,16'h0000,0, 16'h0012,16'h0003,2'd1,0,16'h0000,0,2'd2,1,0);
      add("A_wait2",    0,0,0,2'd0,0,4'h0,0,16'h0000,0, 16'h0012,16'h0003,2'd1,0,16'h0000,0,2'd2,1,0);
      add("A_done",     0,0,0,2'd0,0,4'h0,1,16'h0015,0, 16'h0012,16'h0003,2'd1,0,16'h0015,0,2'd3,0,0);
      add("A_equ_res",  0,1,0,2'd0,0,4'h0,0,16'h0000,0, 16'h0012,16'h0003,2'd1,0,16'h0015,0,2'd3,0,0);
      // chaining from the result: B 2 =
      add("B_opB",      0,0,1,2'd2,0,4'h0,0,16'h0000,0, 16'h0015,16'h0000,2'd2,0,16'h0015,0,2'd1,0,0);
      add("B_num2",     0,0,0,2'd0,1,4'h2,0,16'h0000,0, 16'h0015,16'h0002,2'd2,0,16'h0015,0,2'd2,0,0);
      add("B_equ",      0,1,0,2'd0,0,4'h0,0,16'h0000,0, 16'h0015,16'h0002,2'd2,1,16'h0015,0,2'd2,1,0);
      add("B_done_neg", 0,0,0,2'd0,0,4'h0,1,16'h0030,1, 16'h0015,16'h0002,2'd2,0,16'h0030,1,2'd3,0,0);
      // digit in the result state starts a fresh first operand
      add("R_num7",     0,0,0,2'd0,1,4'h7,0,16'h0000,0, 16'h0007,16'h0000,2'd2,0,16'h0030,1,2'd0,0,0);
      add("R_num4",     0,0,0,2'd0,1,4'h4,0,16'h0000,0, 16'h0074,16'h0000,2'd2,0,16'h0030,1,2'd0,0,0);
      add("R_clear",    1,0,0,2'd0,0,4'h0,0,16'h0000,0, 16'h0000,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      // overflow and invalid digits
      add("F_9",        0,0,0,2'd0,1,4'h9,0,16'h0000,0, 16'h0009,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("F_8",        0,0,0,2'd0,1,4'h8,0,16'h0000,0, 16'h0098,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("F_7",        0,0,0,2'd0,1,4'h7,0,16'h0000,0, 16'h0987,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("F_6",        0,0,0,2'd0,1,4'h6,0,16'h0000,0, 16'h9876,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("F_5_drop",   0,0,0,2'd0,1,4'h5,0,16'h0000,0, 16'h9876,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("F_A_drop",   0,0,0,2'd0,1,4'hA,0,16'h0000,0, 16'h9876,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("F_equ_op1",  0,1,0,2'd0,0,4'h0,0,16'h0000,0, 16'h9876,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      // priority corner cases
      add("P_opA",      0,0,1,2'd1,0,4'h0,0,16'h0000,0, 16'h9876,16'h0000,2'd1,0,16'h0000,0,2'd1,0,0);
      add("P_opB_num5", 0,0,1,2'd2,1,4'h5,0,16'h0000,0, 16'h9876,16'h0000,2'd2,0,16'h0000,0,2'd1,0,0);
      add("P_equ_cnt0", 0,1,0,2'd0,0,4'h0,0,16'h0000,0, 16'h9876,16'h0000,2'd2,0,16'h0000,0,2'd1,0,0);
      add("P_num4",     0,0,0,2'd0,1,4'h4,0,16'h0000,0, 16'h9876,16'h0004,2'd2,0,16'h0000,0,2'd2,0,0);
      add("P_op_cnt1",  0,0,1,2'd1,0,4'h0,0,16'h0000,0, 16'h9876,16'h0004,2'd2,0,16'h0000,0,2'd2,0,0);
      add("P_c_equ",    1,1,0,2'd0,0,4'h0,0,16'h0000,0, 16'h0000,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("P_done_idle",0,0,0,2'd0,0,4'h0,1,16'h9999,1, 16'h0000,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      // abort during execute, late alu_done discarded
      add("X_num3",     0,0,0,2'd0,1,4'h3,0,16'h0000,0, 16'h0003,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("X_opA",      0,0,1,2'd1,0,4'h0,0,16'h0000,0, 16'h0003,16'h0000,2'd1,0,16'h0000,0,2'd1,0,0);
      add("X_num1",     0,0,0,2'd0,1,4'h1,0,16'h0000,0, 16'h0003,16'h0001,2'd1,0,16'h0000,0,2'd2,0,0);
      add("X_equ",      0,1,0,2'd0,0,4'h0,0,16'h0000,0, 16'h0003,16'h0001,2'd1,1,16'h0000,0,2'd2,1,0);
      add("X_keys_ign", 0,0,1,2'd2,1,4'h5,0,16'h0000,0, 16'h0003,16'h0001,2'd1,0,16'h0000,0,2'd2,1,0);
      add("X_clear",    1,0,0,2'd0,0,4'h0,0,16'h0000,0, 16'h0000,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);
      add("X_late_done",0,0,0,2'd0,0,4'h0,1,16'h0042,1, 16'h0000,16'h0000,2'd0,0,16'h0000,0,2'd0,0,0);

      repeat (2) @(posedge clk);
      #1;
      expect_all("reset", '0, '0, 2'd0, 0, '0, 0, 2'd0, 0, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vq[i]) begin
         step(vq[i].c, vq[i].equ, vq[i].op, vq[i].opr, vq[i].num, vq[i].dig,
              vq[i].done, vq[i].res, vq[i].rneg);
         expect_all(vq[i].name, vq[i].e_op1, vq[i].e_op2, vq[i].e_sel, vq[i].e_start,
                    vq[i].e_result, vq[i].e_neg, vq[i].e_disp, vq[i].e_busy, vq[i].e_err);
      end

      // ---- timeout: nonzero result first so the forced zero is visible ----
      step(0,0,0,2'd0,1,4'h1,0,16'h0,0);
      step(0,0,1,2'd1,0,4'h0,0,16'h0,0);
      step(0,0,0,2'd0,1,4'h2,0,16'h0,0);
      step(0,1,0,2'd0,0,4'h0,0,16'h0,0);
      step(0,0,0,2'd0,0,4'h0,1,16'h0015,1);
      expect_all("T_first_res", 16'h0001, 16'h0002, 2'd1, 0, 16'h0015, 1, 2'd3, 0, 0);
      step(0,0,1,2'd2,0,4'h0,0,16'h0,0);
      step(0,0,0,2'd0,1,4'h3,0,16'h0,0);
      step(0,1,0,2'd0,0,4'h0,0,16'h0,0);
      expect_all("T_start", 16'h0015, 16'h0003, 2'd2, 1, 16'h0015, 1, 2'd2, 1, 0);
      for (int k = 1; k <= TMO; k++) begin
         idle();
         n_checks++;
         if (busy !== 1'b1 || err !== 1'b0 || alu_start !== 1'b0) begin
            n_errors++;
            $display("FAIL T_wait%0d: got busy=%b err=%b start=%b; want busy=1 err=0 start=0",
                     k, busy, err, alu_start);
         end
      end
      idle();
      expect_all("T_expired", 16'h0015, 16'h0003, 2'd2, 0, 16'h0000, 0, 2'd3, 0, 1);
      // err is sticky across a successful chained operation
      step(0,0,1,2'd1,0,4'h0,0,16'h0,0);
      step(0,0,0,2'd0,1,4'h1,0,16'h0,0);
      step(0,1,0,2'd0,0,4'h0,0,16'h0,0);
      step(0,0,0,2'd0,0,4'h0,1,16'h0007,0);
      expect_all("T_sticky", 16'h0000, 16'h0001, 2'd1, 0, 16'h0007, 0, 2'd3, 0, 1);
      step(1,0,0,2'd0,0,4'h0,0,16'h0,0);
      expect_all("T_clear_err", '0, '0, 2'd0, 0, '0, 0, 2'd0, 0, 0);

      // ---- reset during execute, then a late alu_done ----
      step(0,0,0,2'd0,1,4'h2,0,16'h0,0);
      step(0,0,1,2'd1,0,4'h0,0,16'h0,0);
      step(0,0,0,2'd0,1,4'h3,0,16'h0,0);
      step(0,1,0,2'd0,0,4'h0,0,16'h0,0);
      idle();
      expect_all("Z_in_exec", 16'h0002, 16'h0003, 2'd1, 0, '0, 0, 2'd2, 1, 0);
      @(negedge clk);
      reset = 1'b1;
      c = 0; equ = 0; op = 0; num = 0; alu_done = 0;
      @(posedge clk);
      #1;
      expect_all("Z_reset", '0, '0, 2'd0, 0, '0, 0, 2'd0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      step(0,0,0,2'd0,0,4'h0,1,16'h0005,1);
      expect_all("Z_late_done", '0, '0, 2'd0, 0, '0, 0, 2'd0, 0, 0);
      step(0,0,0,2'd0,1,4'h8,0,16'h0,0);
      expect_all("Z_op1_entry", 16'h0008, '0, 2'd0, 0, '0, 0, 2'd0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter NDIG, default 4: BCD digits per operand; operand width is 4*NDIG.
REQ-002 Parameter TIMEOUT, default 31: maximum cycles to wait for alu_done.
REQ-003 Port clk, input, 1: single system clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port num, input, 1: one-cycle strobe for a digit key.
REQ-006 Port digit, input, 4: BCD digit qualified by num.
REQ-007 Port op, input, 1: one-cycle strobe for an operator key.
REQ-008 Port operator, input, 2: operator code qualified by op.
REQ-009 Port c, input, 1: clear strobe.
REQ-010 Port equ, input, 1: equals strobe.
REQ-011 Port alu_done, input, 1: ALU result-valid pulse.
REQ-012 Port alu_res, input, 16: BCD result magnitude.
REQ-013 Port alu_neg, input, 1: negative-result flag, valid with alu_done.
REQ-014 Port op1, output, 16: first operand, BCD.
REQ-015 Port op2, output, 16: second operand, BCD.
REQ-016 Port op_sel, output, 2: latched operator.
REQ-017 Port alu_start, output, 1: one-cycle ALU launch pulse.
REQ-018 Port result, output, 16: latched result.
REQ-019 Port neg, output, 1: latched sign of result.
REQ-020 Port disp_sel, output, 2: display source; 00 = op1, 01 = operator, 10 = op2, 11 = result.
REQ-021 Port busy, output, 1: high while in S_EXEC.
REQ-022 Port err, output, 1: sticky ALU-timeout flag.

Function
REQ-023 States SHALL be S_OP1, S_OP2, S_EXEC and S_RES; each operand has a digit counter running 0..NDIG.
REQ-024 Input priority when strobes coincide SHALL be c > equ > op > num; lower-priority strobes in the same cycle are dropped.
REQ-025 A num with digit > 9 SHALL be ignored.
REQ-026 S_OP1 or S_OP2 with a valid num and count < NDIG: the operand shifts left one digit, digit enters the LSD, count increments; at count == NDIG the digit is ignored (no wrap).
REQ-027 S_OP1 with op: latch op_sel (op1 may still be 0), clear op2 and its count, go to S_OP2.
REQ-028 S_OP2 with op and count == 0: replace op_sel; with count > 0: ignore.
REQ-029 S_OP2 with equ and count > 0: alu_start is high exactly the next cycle and the state is S_EXEC; equ with count == 0 is ignored, as is equ in S_OP1.
REQ-030 op1, op2 and op_sel SHALL hold stable from equ acceptance until S_EXEC is exited.
REQ-031 In S_EXEC, num, op and equ SHALL be ignored; c aborts to S_OP1 with all operands cleared, and a later alu_done is discarded.
REQ-032 In S_EXEC with alu_done: result <= alu_res, neg <= alu_neg, err unchanged, go to S_RES on the next cycle.
REQ-033 If alu_done is not seen within TIMEOUT cycles after alu_start: result <= 0, neg <= 0, err <= 1, go to S_RES.
REQ-034 alu_done outside S_EXEC SHALL be ignored.
REQ-035 S_RES with num: op1 <= digit, count1 <= 1, op2 cleared, go to S_OP1.
REQ-036 S_RES with op: op1 <= result, op_sel latched, go to S_OP2 (chaining); equ is ignored.
REQ-037 c in any state SHALL clear op1, op2, op_sel, result, neg, err and both counts, and go to S_OP1.
REQ-038 disp_sel SHALL be a registered decode of the state: S_OP1 -> 00; S_OP2 with count 0 -> 01; S_OP2 with count > 0 -> 10; S_EXEC -> 10; S_RES -> 11.

Reset
REQ-039 On reset: state S_OP1; all outputs 0, including alu_start, busy, err and disp_sel = 00; both counts 0; the timeout counter is cleared.

Structure
REQ-040 Package calc_pkg SHALL hold the state encoding, disp_sel codes, operator codes (A = 01, B = 10) and the NDIG/TIMEOUT defaults.
REQ-041 Sub-module bcd_entry_reg (shift register plus digit counter, with load and clear inputs) SHALL be instantiated twice, once per operand.

Verification
REQ-042 Scenario: keys 1, 2, A, 3, equ, then alu_done with alu_res = 0x0015 three cycles later -> op1 = 0x0012, op_sel = 01, op2 = 0x0003, alu_start pulses once, result = 0x0015, disp_sel = 11.
REQ-043 Scenario: digits 9, 8, 7, 6, 5 -> op1 = 0x9876, fifth digit dropped; a num with digit = 0xA is also dropped.
REQ-044 Scenario: after equ, no alu_done for 31 cycles -> err = 1, result = 0, state S_RES; a c afterwards clears err.
REQ-045 Scenario: op and num asserted in the same cycle in S_OP2 with count 0 -> only op_sel is updated, op2 stays 0; c and equ together -> clear wins, no alu_start.
REQ-046 Scenario: in S_RES with result 0x0015, press B then 2 then equ -> op1 = 0x0015, op_sel = 10, op2 = 0x0002, alu_start pulses.
REQ-047 Scenario: reset asserted mid-S_EXEC, then a late alu_done -> all outputs 0, state S_OP1, alu_done ignored.
